// File: rtl/fp_mul_arbiter_if.sv
// Requester and multiplier bus for fp_mul_arbiter.
// The slave view belongs to the arbiter. The master view belongs to whatever
// sits around it: the requesters and the external fp_mul instance.
interface fp_mul_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [NUM_REQ-1:0]    resp_ready;
  logic [31:0]           resp_y;
  logic                  resp_underflow;
  logic                  resp_overflow;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic [31:0]           mul_y;
  logic                  mul_underflow;
  logic                  mul_overflow;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, mul_y, mul_underflow, mul_overflow,
    output req_ready, resp_valid, resp_y, resp_underflow, resp_overflow, mul_a, mul_b
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready, mul_y, mul_underflow, mul_overflow,
    input  req_ready, resp_valid, resp_y, resp_underflow, resp_overflow, mul_a, mul_b
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin sequencer sharing one multi-cycle fp_mul among NUM_REQ requesters.
// It accepts one operand pair, holds it on the multiplier for MUL_LATENCY cycles,
// captures the product and flags, and returns them to the granted requester.
//
// state  | meaning
// IDLE   | no operation in flight; req_ready offers the rotated-priority winner
// BUSY   | operands held on the multiplier; cnt_q counts down to the capture edge
// RESP   | result held; waiting for resp_ready of the granted requester
module fp_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  fp_mul_arbiter_if.slave       bus,
  output logic                  busy_o,
  output logic [15:0]           op_count_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 4;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   grant_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        opa_q;
  logic [31:0]        opb_q;
  logic [31:0]        y_q;
  logic               uf_q;
  logic               of_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [15:0]        op_count_q;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  int unsigned        scan_idx;
  logic [NUM_REQ-1:0] req_ready_w;

  // Rotated-priority search from rr_ptr_q; the offer is only made in IDLE and out of reset.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    scan_idx    = 0;
    req_ready_w = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!pick_found && bus.req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(scan_idx);
      end
    end
    if (rst_n_i && state_q == S_IDLE && pick_found) req_ready_w = ONE_HOT0 << pick_idx;
  end

  // Sequencer: accept, hold operands, capture, then return the result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      cnt_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      y_q          <= '0;
      uf_q         <= 1'b0;
      of_q         <= 1'b0;
      resp_valid_q <= '0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|(bus.req_valid & req_ready_w)) begin
            opa_q   <= bus.req_a[32*int'(pick_idx) +: 32];
            opb_q   <= bus.req_b[32*int'(pick_idx) +: 32];
            grant_q <= pick_idx;
            cnt_q   <= CNT_W'(MUL_LATENCY);
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            y_q          <= bus.mul_y;
            uf_q         <= bus.mul_underflow;
            of_q         <= bus.mul_overflow;
            resp_valid_q <= ONE_HOT0 << grant_q;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready[grant_q]) begin
            resp_valid_q <= '0;
            rr_ptr_q     <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            op_count_q   <= op_count_q + 16'd1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = req_ready_w;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_y         = y_q;
  assign bus.resp_underflow = uf_q;
  assign bus.resp_overflow  = of_q;
  assign bus.mul_a          = opa_q;
  assign bus.mul_b          = opb_q;
  assign busy_o             = (state_q != S_IDLE);
  assign op_count_o         = op_count_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a small lookup-table multiplier model.
// The model has a one-register pipeline, so its output reflects operands that
// were present one edge earlier.
module tb_fp_mul_arbiter;
  localparam int N = 4;
  localparam int L = 2;

  localparam logic [31:0] F1_0 = 32'h3F800000;
  localparam logic [31:0] F1_5 = 32'h3FC00000;
  localparam logic [31:0] F2_0 = 32'h40000000;
  localparam logic [31:0] F3_0 = 32'h40400000;
  localparam logic [31:0] F5_0 = 32'h40A00000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        busy;
  logic [15:0] op_count;
  logic [31:0] pipe_y = 32'h0;
  logic        force_ovf = 1'b0;
  logic        force_udf = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  fp_mul_arbiter_if #(.NUM_REQ(N)) bus ();

  fp_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .bus        (bus),
    .busy_o     (busy),
    .op_count_o (op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == F1_0) return b;
    if (b == F1_0) return a;
    if (a == F2_0 && b == F3_0) return 32'h40C00000;
    if (a == F1_5 && b == F1_5) return 32'h40100000;
    return 32'h7FC00000;
  endfunction

  always @(posedge clk) pipe_y <= fmul(bus.mul_a, bus.mul_b);
  assign bus.mul_y         = pipe_y;
  assign bus.mul_overflow  = force_ovf;
  assign bus.mul_underflow = force_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = '0;
    rst_n = 1'b0;

    // reset state, with a request already pending
    set_req(0, F2_0, F3_0);
    bus.req_valid  = 4'b0001;
    bus.resp_ready = 4'b1111;
    #2;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_op_count", 32'(op_count), 32'h0);
    chk("rst_mul_a", bus.mul_a, 32'h0);
    chk("rst_mul_b", bus.mul_b, 32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_y", bus.resp_y, 32'h0);

    // single op: 2.0 * 3.0
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("single_req_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_ready_busy", 32'(bus.req_ready), 32'h0);
    chk("single_mul_a", bus.mul_a, F2_0);
    chk("single_mul_b", bus.mul_b, F3_0);
    chk("single_no_resp_e0", 32'(bus.resp_valid), 32'h0);
    tick();
    chk("single_no_resp_e1", 32'(bus.resp_valid), 32'h0);
    tick();
    chk("single_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("single_resp_y", bus.resp_y, 32'h40C00000);
    chk("single_resp_ovf", 32'(bus.resp_overflow), 32'h0);
    tick();
    chk("single_done_valid", 32'(bus.resp_valid), 32'h0);
    chk("single_done_busy", 32'(busy), 32'h0);
    chk("single_op_count", 32'(op_count), 32'h1);

    // round robin from reset: all four valid with 1.5 * 1.5
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    chk("rr_op_count_cleared", 32'(op_count), 32'h0);
    for (int i = 0; i < N; i++) set_req(i, F1_5, F1_5);
    bus.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rr_grant%0d", k), 32'(bus.req_ready), 32'h1 << k);
      tick();
      bus.req_valid[k] = 1'b0;
      chk($sformatf("rr_busy_ready%0d", k), 32'(bus.req_ready), 32'h0);
      tick();
      tick();
      chk($sformatf("rr_resp_valid%0d", k), 32'(bus.resp_valid), 32'h1 << k);
      chk($sformatf("rr_resp_y%0d", k), bus.resp_y, 32'h40100000);
      tick();
    end
    chk("rr_op_count", 32'(op_count), 32'h4);

    // rotation: requester 2 completes, then 1 and 3 compete
    set_req(2, F1_0, F5_0);
    bus.req_valid = 4'b0100;
    #1;
    chk("rot_grant2", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    chk("rot_resp_y2", bus.resp_y, F5_0);
    tick();
    set_req(1, F2_0, F1_0);
    set_req(3, F1_0, F1_5);
    bus.req_valid = 4'b1010;
    #1;
    chk("rot_3_first", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid[3] = 1'b0;
    chk("rot_1_waits", 32'(bus.req_ready), 32'h0);
    tick();
    tick();
    chk("rot_resp_valid3", 32'(bus.resp_valid), 32'h8);
    chk("rot_resp_y3", bus.resp_y, F1_5);
    tick();
    chk("rot_then_1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    chk("rot_resp_y1", bus.resp_y, F2_0);
    tick();
    chk("rot_op_count", 32'(op_count), 32'h7);

    // backpressure on requester 0, others ready and another request pending
    set_req(0, F2_0, F3_0);
    bus.resp_ready = 4'b1110;
    bus.req_valid  = 4'b0001;
    #1;
    chk("bp_grant0", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(1, F1_0, F5_0);
    bus.req_valid = 4'b0010;
    tick();
    tick();
    force_ovf = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid%0d", c), 32'(bus.resp_valid), 32'h1);
      chk($sformatf("bp_y%0d", c), bus.resp_y, 32'h40C00000);
      chk($sformatf("bp_ovf%0d", c), 32'(bus.resp_overflow), 32'h0);
      chk($sformatf("bp_no_ready%0d", c), 32'(bus.req_ready), 32'h0);
      tick();
    end
    bus.resp_ready = 4'b1111;
    tick();
    chk("bp_done_valid", 32'(bus.resp_valid), 32'h0);
    chk("bp_next_grant1", 32'(bus.req_ready), 32'h2);
    chk("bp_op_count", 32'(op_count), 32'h8);

    // overflow flag captured for requester 1
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    chk("flag_ovf", 32'(bus.resp_overflow), 32'h1);
    chk("flag_udf_clear", 32'(bus.resp_underflow), 32'h0);
    chk("flag_y", bus.resp_y, F5_0);
    force_ovf = 1'b0;
    tick();
    chk("flag_op_count", 32'(op_count), 32'h9);

    // reset one cycle after accept
    set_req(2, F2_0, F3_0);
    bus.req_valid = 4'b0100;
    #1;
    chk("mid_grant2", 32'(bus.req_ready), 32'h4);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_mul_a", bus.mul_a, 32'h0);
    chk("mid_mul_b", bus.mul_b, 32'h0);
    chk("mid_req_ready", 32'(bus.req_ready), 32'h0);
    chk("mid_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("mid_op_count", 32'(op_count), 32'h0);
    chk("mid_resp_y", bus.resp_y, 32'h0);
    tick();
    bus.req_valid = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("mid_no_resp%0d", c), 32'(bus.resp_valid), 32'h0);
    end
    set_req(0, F1_0, F2_0);
    set_req(2, F1_0, F3_0);
    bus.req_valid = 4'b0101;
    force_udf = 1'b1;
    #1;
    chk("post_rst_grant0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    chk("post_rst_valid0", 32'(bus.resp_valid), 32'h1);
    chk("post_rst_udf", 32'(bus.resp_underflow), 32'h1);
    chk("post_rst_y", bus.resp_y, F2_0);
    force_udf = 1'b0;
    tick();
    chk("post_rst_op_count", 32'(op_count), 32'h1);

    // op_count wrap
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    #1;
    chk("wrap_preload", 32'(op_count), 32'hFFFF);
    set_req(1, F1_0, F1_5);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    tick();
    chk("wrap_op_count", 32'(op_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle `fp_mul` single-precision multiplier among `NUM_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and holds the multiplier operands stable for the full multiplier latency. It then captures the product and flags and returns them to the granted requester over a second valid/ready handshake. It sits between the requester ports and the multiplier instance; the multiplier itself is instantiated outside this block.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MUL_LATENCY`, 2: cycles from operands stable at the multiplier to a valid `mul_y`, 1..15.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input NUM_REQ: per-requester operand valid.
- `req_a` input 32*NUM_REQ: operand A, requester i at bits [32i+31:32i].
- `req_b` input 32*NUM_REQ: operand B, same packing.
- `req_ready` output NUM_REQ: one-hot accept. Transfer occurs on an edge where `req_valid[i] & req_ready[i]`.
- `resp_valid` output NUM_REQ: one-hot result valid to the granted requester.
- `resp_ready` input NUM_REQ: per-requester result accept.
- `resp_y` output 32: product (IEEE 754 single), shared by all requesters.
- `resp_underflow`, `resp_overflow` output 1 each: captured multiplier flags.
- `mul_a`, `mul_b` output 32 each: operands driven to the multiplier.
- `mul_y` input 32; `mul_underflow`, `mul_overflow` input 1 each: multiplier outputs.
- `busy` output 1: high in any state other than IDLE.
- `op_count` output 16: completed operations, wraps 0xFFFF -> 0x0000.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - `req_ready` is combinational. It equals the one-hot of the first index with `req_valid` set, searching from `rr_ptr` upward modulo NUM_REQ. It is zero if no request is pending.
  - On transfer: latch A/B into the operand registers, latch the grant index, load `cnt = MUL_LATENCY`, go to BUSY.
- BUSY:
  - `mul_a`/`mul_b` are driven from the operand registers and held constant. `req_ready = 0`.
  - `cnt` decrements each cycle.
  - On the edge where `cnt == 1`: capture `mul_y`/flags into the result registers and go to RESP.
- RESP:
  - `resp_valid[grant]=1`. `resp_y`/flags are stable.
  - On an edge with `resp_ready[grant]=1`: set `rr_ptr = (grant+1) mod NUM_REQ`, increment `op_count`, go to IDLE.
  - `resp_ready` of non-granted requesters is ignored.
- Requesters must hold `req_valid`/operands stable until accepted. The block never drops a request it has not accepted.
- `rr_ptr` advances only on response completion. A requester that is sole-valid repeatedly is granted every operation.
- Operands pass through unmodified. No special-case (zero/inf/NaN) handling in this block.

## Timing
- Reset values: state IDLE, `rr_ptr=0`, `cnt=0`, operand and result registers 0, `mul_a=mul_b=0`, `resp_y=0`, flags 0, `resp_valid=0`, `busy=0`, `op_count=0`.
- While in reset, `req_ready=0`.
- Latency: with the accept edge as E0, `resp_valid` rises after edge E0+MUL_LATENCY. Minimum issue interval is MUL_LATENCY+2 cycles (accept, MUL_LATENCY BUSY cycles, one RESP cycle; IDLE re-grant is combinational on the cycle after RESP).
- Back-to-back: with `resp_ready` held high, the next `req_ready` asserts in the cycle after the RESP completion edge.
- Simultaneous requests: exactly one grant. Priority is rotated from `rr_ptr`.
- `req_valid` deasserted in IDLE before an edge: no transfer, nothing latched.
- Reset mid-operation (BUSY or RESP): all state returns to reset values immediately. The in-flight result is discarded with no `resp_valid`.
- `op_count` wrap: 0xFFFF plus one completion gives 0x0000.

## Test plan
- Single op: after reset, req0 a=0x40000000 (2.0), b=0x40400000 (3.0), `resp_ready[0]=1`, MUL_LATENCY=2 -> `req_ready[0]` high at accept. `resp_valid[0]` rises 2 cycles after accept with `resp_y=0x40C00000`. `op_count=1`.
- Round-robin: all 4 requesters valid from reset with a=b=0x3FC00000 (1.5) -> grants in order 0,1,2,3. Each response is `0x40100000`. The issue interval is 4 cycles.
- Rotation: after requester 2 completes, requesters 1 and 3 are both valid -> 3 is granted before 1.
- Backpressure: `resp_ready[0]=0` for 5 cycles in RESP -> `resp_valid[0]`, `resp_y` and flags stay stable. No `req_ready` to other valid requesters until the completion edge.
- Reset mid-BUSY: assert `rst_n=0` one cycle after accept -> all outputs return to reset values asynchronously. No `resp_valid` ever appears for that op. A new request after release is served with grant starting at index 0.
- Flags/wrap: model returns `mul_overflow=1` -> `resp_overflow=1` in RESP. Preload 65535 completions, then one more -> `op_count=0x0000`.
